regfile_access_ctrl: RTL

Initiator side of the register-file read/write interface in the multi-cycle MIPS32 datapath.
- Accepts operand-fetch requests from decode and result writebacks from the execute/memory stages.
- Drives the register file's ReadReg1/ReadReg2/WriteReg/WriteData/RegWrite ports and latches ReadData1/ReadData2 into the A/B operand registers.
- Keeps a busy scoreboard so no operand is read before its pending producer has written back.

---
 rtl/mips_rf_pkg.sv | 26 ++
 rtl/regfile_access_ctrl_if.sv | 69 ++++++
 rtl/rf_scoreboard.sv | 63 ++++++
 rtl/regfile_access_ctrl.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/mips_rf_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_rf_pkg
// Purpose  : Shared defaults, constants and FSM state encoding for the
//            register-file access controller of the multi-cycle MIPS32 datapath.
// Contents : DATA_W_DEF / ADDR_W_DEF default widths, NUM_REGS, REG_ZERO,
//            state_t (IDLE / READ / HOLD).
// Revision : 1.0 - initial release
// ============================================================================
package mips_rf_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NUM_REGS   = 2 ** ADDR_W_DEF;

  // Index of the hard-wired zero register; it can never hold a pending result.
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage : mips_rf_pkg
`default_nettype wire

// File: rtl/regfile_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl_if
// Purpose  : Bundles the issue, writeback, register-file and operand
//            handshakes of regfile_access_ctrl.
// Modports : slave  - the controller (accepts issue/writeback, drives file)
//            master - the surrounding datapath (decode, EX/MEM, file, consumer)
// Revision : 1.0 - initial release
// ============================================================================
interface regfile_access_ctrl_if
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  // Operand-fetch request from decode
  logic              IssueValid;
  logic              IssueReady;
  logic [ADDR_W-1:0] IssueRs;
  logic [ADDR_W-1:0] IssueRt;
  logic [ADDR_W-1:0] IssueRd;
  logic              IssueRdEn;

  // Result writeback from execute/memory
  logic              WbValid;
  logic [ADDR_W-1:0] WbReg;
  logic [DATA_W-1:0] WbData;

  // Register-file ports
  logic [ADDR_W-1:0] ReadReg1;
  logic [ADDR_W-1:0] ReadReg2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;

  // Operand delivery to the consumer
  logic              OperandValid;
  logic              OperandReady;
  logic [DATA_W-1:0] OperandA;
  logic [DATA_W-1:0] OperandB;
  logic [ADDR_W-1:0] OperandTag;

  modport slave (
    input  IssueValid, IssueRs, IssueRt, IssueRd, IssueRdEn,
    output IssueReady,
    input  WbValid, WbReg, WbData,
    output ReadReg1, ReadReg2,
    input  ReadData1, ReadData2,
    output WriteReg, WriteData, RegWrite,
    output OperandValid, OperandA, OperandB, OperandTag,
    input  OperandReady
  );

  modport master (
    output IssueValid, IssueRs, IssueRt, IssueRd, IssueRdEn,
    input  IssueReady,
    output WbValid, WbReg, WbData,
    input  ReadReg1, ReadReg2,
    output ReadData1, ReadData2,
    input  WriteReg, WriteData, RegWrite,
    input  OperandValid, OperandA, OperandB, OperandTag,
    output OperandReady
  );

endinterface : regfile_access_ctrl_if
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Purpose  : Busy mask with one bit per architectural register. A bit is set
//            when a producer is issued and cleared when its result is written
//            back. Set wins over clear on the same register in the same cycle,
//            because the set belongs to the newer producer.
// Ports    : clk, rst_n            - clock, async active-low reset
//            i_set_en / i_set_reg  - mark register busy
//            i_clr_en / i_clr_reg  - mark register free
//            i_q1_reg / o_q1_busy  - query port 1
//            i_q2_reg / o_q2_busy  - query port 2
// Revision : 1.0 - initial release
// ============================================================================
module rf_scoreboard
  import mips_rf_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              i_set_en,
  input  wire logic [ADDR_W-1:0] i_set_reg,
  input  wire logic              i_clr_en,
  input  wire logic [ADDR_W-1:0] i_clr_reg,
  input  wire logic [ADDR_W-1:0] i_q1_reg,
  input  wire logic [ADDR_W-1:0] i_q2_reg,
  output logic                   o_q1_busy,
  output logic                   o_q2_busy
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  always_comb begin
    w_busy_next = r_busy;
    for (int i = 0; i < NREGS; i++) begin
      if (i_clr_en && (i_clr_reg == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b0;
      end
      // Evaluated after the clear so a same-cycle set takes priority.
      if (i_set_en && (i_set_reg == ADDR_W'(i))) begin
        w_busy_next[i] = 1'b1;
      end
    end
    w_busy_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_q1_busy = r_busy[i_q1_reg];
  assign o_q2_busy = r_busy[i_q2_reg];

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Purpose  : Initiator side of the register-file interface. Accepts operand
//            fetches (stalling on pending producers), reads rs/rt through the
//            file's read ports, holds A/B operands until consumed, and
//            forwards result writebacks to the file as one-cycle pulses.
// Ports    : Clk, Rst_n - clock (rising edge), async active-low reset
//            bus        - regfile_access_ctrl_if.slave (issue, writeback,
//                         register-file ports, operand handshake)
// Options  : REGFILE_FWD_EN - when defined, a writeback in the same cycle as
//            an issue releases the stall, and the READ cycle bypasses the
//            in-flight write data into the operand latches.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_access_ctrl
  import mips_rf_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input wire logic             Clk,
  input wire logic             Rst_n,
  regfile_access_ctrl_if.slave bus
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_read_reg1;
  logic [ADDR_W-1:0] r_read_reg2;
  logic [ADDR_W-1:0] r_pend_tag;
  logic [ADDR_W-1:0] r_op_tag;
  logic [DATA_W-1:0] r_op_a;
  logic [DATA_W-1:0] r_op_b;
  logic              r_op_valid;
  logic [ADDR_W-1:0] r_write_reg;
  logic [DATA_W-1:0] r_write_data;
  logic              r_reg_write;

  logic              w_rs_busy;
  logic              w_rt_busy;
  logic              w_rs_blocked;
  logic              w_rt_blocked;
  logic              w_issue_ready;
  logic              w_issue_fire;
  logic              w_wb_fire;
  logic              w_set_en;
  logic [DATA_W-1:0] w_opnd_a;
  logic [DATA_W-1:0] w_opnd_b;

  // Writes to r0 are dropped entirely: no pulse, no scoreboard effect.
  assign w_wb_fire = bus.WbValid && (bus.WbReg != '0);
  assign w_set_en  = w_issue_fire && bus.IssueRdEn && (bus.IssueRd != '0);

  rf_scoreboard #(
    .ADDR_W (ADDR_W)
  ) u_scoreboard (
    .clk       (Clk),
    .rst_n     (Rst_n),
    .i_set_en  (w_set_en),
    .i_set_reg (bus.IssueRd),
    .i_clr_en  (w_wb_fire),
    .i_clr_reg (bus.WbReg),
    .i_q1_reg  (bus.IssueRs),
    .i_q2_reg  (bus.IssueRt),
    .o_q1_busy (w_rs_busy),
    .o_q2_busy (w_rt_busy)
  );

`ifdef REGFILE_FWD_EN
  // A producer finishing this cycle no longer blocks its consumers; the
  // following READ cycle overlaps the RegWrite pulse, so the file still holds
  // the old value and the write data is bypassed instead.
  assign w_rs_blocked = w_rs_busy && !(w_wb_fire && (bus.WbReg == bus.IssueRs));
  assign w_rt_blocked = w_rt_busy && !(w_wb_fire && (bus.WbReg == bus.IssueRt));
  assign w_opnd_a = (r_reg_write && (r_write_reg == r_read_reg1) && (r_read_reg1 != '0))
                    ? r_write_data : bus.ReadData1;
  assign w_opnd_b = (r_reg_write && (r_write_reg == r_read_reg2) && (r_read_reg2 != '0))
                    ? r_write_data : bus.ReadData2;
`else
  assign w_rs_blocked = w_rs_busy;
  assign w_rt_blocked = w_rt_busy;
  assign w_opnd_a     = bus.ReadData1;
  assign w_opnd_b     = bus.ReadData2;
`endif

  // Gated by Rst_n so that IssueReady is also low while reset is held.
  assign w_issue_ready = Rst_n && (r_state == IDLE) && !w_rs_blocked && !w_rt_blocked;
  assign w_issue_fire  = bus.IssueValid && w_issue_ready;

  // Operand-fetch FSM
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_state     <= IDLE;
      r_read_reg1 <= '0;
      r_read_reg2 <= '0;
      r_pend_tag  <= '0;
      r_op_tag    <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_valid  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_issue_fire) begin
            r_read_reg1 <= bus.IssueRs;
            r_read_reg2 <= bus.IssueRt;
            r_pend_tag  <= bus.IssueRdEn ? bus.IssueRd : '0;
            r_state     <= READ;
          end
        end
        READ: begin
          r_op_a     <= w_opnd_a;
          r_op_b     <= w_opnd_b;
          r_op_tag   <= r_pend_tag;
          r_op_valid <= 1'b1;
          r_state    <= HOLD;
        end
        HOLD: begin
          if (bus.OperandReady) begin
            r_op_valid <= 1'b0;
            r_state    <= IDLE;
          end
        end
        default: begin
          r_op_valid <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Writeback path: independent of the FSM and never stalled.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
    end else begin
      r_reg_write <= w_wb_fire;
      if (w_wb_fire) begin
        r_write_reg  <= bus.WbReg;
        r_write_data <= bus.WbData;
      end
    end
  end

  assign bus.IssueReady   = w_issue_ready;
  assign bus.ReadReg1     = r_read_reg1;
  assign bus.ReadReg2     = r_read_reg2;
  assign bus.WriteReg     = r_write_reg;
  assign bus.WriteData    = r_write_data;
  assign bus.RegWrite     = r_reg_write;
  assign bus.OperandValid = r_op_valid;
  assign bus.OperandA     = r_op_a;
  assign bus.OperandB     = r_op_b;
  assign bus.OperandTag   = r_op_tag;

endmodule : regfile_access_ctrl
`default_nettype wire
